// File: rtl/stereo_arb_pkg.sv
// Shared encodings for the stereo FIFO read arbiter: source tag, FSM states and a
// constant-foldable clog2 used to size counters.
package stereo_arb_pkg;

    typedef enum logic {
        SRC_LEFT  = 1'b0,
        SRC_RIGHT = 1'b1
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/arb_skid_buf.sv
// Small shift-style FIFO holding {last,src,data}; entry 0 is always the head, so the
// pop-side outputs come straight from flops and hold still while the consumer stalls.
module arb_skid_buf
    import stereo_arb_pkg::*;
#(
    parameter int WIDTH = 26,
    parameter int DEPTH = 2,
    parameter int OW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [OW-1:0]    occupancy
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [OW-1:0]    cnt_q;
    logic [OW-1:0]    cnt_d;
    logic [OW-1:0]    base_s;
    logic             pop_s;

    // Next-state: shift out the head on pop, then append the pushed word behind the survivors.
    always_comb begin
        mem_d  = mem_q;
        pop_s  = (cnt_q != {OW{1'b0}}) && pop_ready;
        base_s = pop_s ? (cnt_q - OW'(1'b1)) : cnt_q;
        if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
        end else begin
            mem_d = mem_q;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (OW'(i) == base_s) begin
                    mem_d[i] = push_data;
                end else begin
                    mem_d[i] = mem_d[i];
                end
            end
            cnt_d = base_s + OW'(1'b1);
        end else begin
            cnt_d = base_s;
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {OW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            cnt_q <= cnt_d;
            mem_q <= mem_d;
        end
    end

    assign pop_valid = (cnt_q != {OW{1'b0}});
    assign pop_data  = mem_q[0];
    assign occupancy = cnt_q;

endmodule

// File: rtl/stereo_fifo_rd_arbiter.sv
// Round-robin burst arbiter merging the Left/Right FIFO read ports into one tagged stream.
// Optional per-source word and burst counters are enabled by STEREO_ARB_STATS_EN.
module stereo_fifo_rd_arbiter
    import stereo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [DATA_WIDTH-1:0] l_rd_data,
    input  logic [ADDR_WIDTH:0]   l_rd_water_level,
    input  logic                  l_empty,
    output logic                  l_rd_en,
    input  logic [DATA_WIDTH-1:0] r_rd_data,
    input  logic [ADDR_WIDTH:0]   r_rd_water_level,
    input  logic                  r_empty,
    output logic                  r_rd_en,
    input  logic                  flush_req,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_src,
    output logic                  out_last,
    output logic                  busy
`ifdef STEREO_ARB_STATS_EN
    ,
    output logic [31:0]           l_word_cnt,
    output logic [31:0]           r_word_cnt,
    output logic [15:0]           burst_cnt
`endif
);

    localparam int CW    = clog2(BURST_LEN + 1);
    localparam int DEPTH = RD_LATENCY + 1;
    localparam int OW    = clog2(DEPTH + 1);
    localparam int LW    = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(BURST_LEN);
    localparam logic [CW-1:0] LEN_FULL = CW'(BURST_LEN);
    localparam logic [CW:0]   CAP      = (CW + 1)'(DEPTH);

    state_e                state_q, state_d;
    src_e                  src_q, src_d, rr_q, rr_d, grant_s;
    logic [CW-1:0]         len_q, len_d, issued_q, issued_d, inflight_q, inflight_d;
    logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
    logic                  l_elig_s, r_elig_s, rd_s, arrive_s, pop_s, sel_empty_s, head_valid_s;
    logic [LW-1:0]         lvl_s;
    logic [CW:0]           load_s;
    logic [OW-1:0]         occ_s;
    logic [DATA_WIDTH+1:0] push_word_s, head_s;

    // Eligibility, grant choice and issue permission.
    always_comb begin
        l_elig_s    = (l_rd_water_level >= FULL_LVL) || (flush_req && (l_rd_water_level != {LW{1'b0}}));
        r_elig_s    = (r_rd_water_level >= FULL_LVL) || (flush_req && (r_rd_water_level != {LW{1'b0}}));
        grant_s     = (l_elig_s && r_elig_s) ? rr_q : (r_elig_s ? SRC_RIGHT : SRC_LEFT);
        lvl_s       = (grant_s == SRC_RIGHT) ? r_rd_water_level : l_rd_water_level;
        sel_empty_s = (src_q == SRC_RIGHT) ? r_empty : l_empty;
        pop_s       = head_valid_s && out_ready;
        // A word leaving the skid this cycle frees its slot, which keeps 1 word/clk sustainable.
        load_s      = (CW + 1)'(occ_s) + (CW + 1)'(inflight_q) - (CW + 1)'(pop_s);
        rd_s        = (state_q == ST_BURST) && (issued_q < len_q) && (load_s < CAP) && !sel_empty_s;
    end

    // FSM and burst counters next-state.
    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        rr_d     = rr_q;
        len_d    = len_q;
        issued_d = issued_q;
        case (state_q)
            ST_IDLE: begin
                if (l_elig_s || r_elig_s) begin
                    src_d    = grant_s;
                    rr_d     = (grant_s == SRC_LEFT) ? SRC_RIGHT : SRC_LEFT;
                    len_d    = (lvl_s >= FULL_LVL) ? LEN_FULL : CW'(lvl_s);
                    issued_d = {CW{1'b0}};
                    state_d  = ST_BURST;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (rd_s) begin
                    issued_d = issued_q + CW'(1'b1);
                    state_d  = (issued_d == len_q) ? ST_DRAIN : ST_BURST;
                end else begin
                    state_d  = ST_BURST;
                end
            end
            ST_DRAIN: begin
                if ((inflight_q == {CW{1'b0}}) && (occ_s == {OW{1'b0}})) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-latency tracking: valid/last tags travel alongside the FIFO's read pipeline.
    always_comb begin
        vld_pipe_d     = vld_pipe_q;
        last_pipe_d    = last_pipe_q;
        vld_pipe_d[0]  = rd_s;
        last_pipe_d[0] = rd_s && (issued_q == (len_q - CW'(1'b1)));
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            last_pipe_d[i] = last_pipe_q[i-1];
        end
        arrive_s    = vld_pipe_q[RD_LATENCY-1];
        inflight_d  = inflight_q + CW'(rd_s) - CW'(arrive_s);
        // src_q cannot change while words are in flight: DRAIN waits for them.
        push_word_s = {last_pipe_q[RD_LATENCY-1], src_q, (src_q == SRC_RIGHT) ? r_rd_data : l_rd_data};
    end

    // Control registers.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_LEFT;
            rr_q        <= SRC_LEFT;
            len_q       <= {CW{1'b0}};
            issued_q    <= {CW{1'b0}};
            inflight_q  <= {CW{1'b0}};
            vld_pipe_q  <= {RD_LATENCY{1'b0}};
            last_pipe_q <= {RD_LATENCY{1'b0}};
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            rr_q        <= rr_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            inflight_q  <= inflight_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
        end
    end

    arb_skid_buf #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (DEPTH),
        .OW    (OW)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (arrive_s),
        .push_data (push_word_s),
        .pop_valid (head_valid_s),
        .pop_ready (out_ready),
        .pop_data  (head_s),
        .occupancy (occ_s)
    );

    assign l_rd_en   = rd_s && (src_q == SRC_LEFT);
    assign r_rd_en   = rd_s && (src_q == SRC_RIGHT);
    assign out_data  = head_s[DATA_WIDTH-1:0];
    assign out_src   = head_s[DATA_WIDTH];
    assign out_last  = head_s[DATA_WIDTH+1];
    assign out_valid = head_valid_s;
    assign busy      = (state_q != ST_IDLE) || (occ_s != {OW{1'b0}}) || (inflight_q != {CW{1'b0}});

`ifdef STEREO_ARB_STATS_EN
    logic [31:0] l_word_cnt_q, l_word_cnt_d, r_word_cnt_q, r_word_cnt_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;

    // Accepted-word and accepted-burst statistics, free-running modulo width.
    always_comb begin
        l_word_cnt_d = (pop_s && !out_src) ? l_word_cnt_q + 32'd1 : l_word_cnt_q;
        r_word_cnt_d = (pop_s && out_src)  ? r_word_cnt_q + 32'd1 : r_word_cnt_q;
        burst_cnt_d  = (pop_s && out_last) ? burst_cnt_q + 16'd1  : burst_cnt_q;
    end

    // Statistics registers.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            l_word_cnt_q <= 32'd0;
            r_word_cnt_q <= 32'd0;
            burst_cnt_q  <= 16'd0;
        end else begin
            l_word_cnt_q <= l_word_cnt_d;
            r_word_cnt_q <= r_word_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign l_word_cnt = l_word_cnt_q;
    assign r_word_cnt = r_word_cnt_q;
    assign burst_cnt  = burst_cnt_q;
`endif

endmodule
